// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TCK driver: FSM encoding, step field layout
// and capture RAM geometry.
package jtag_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAck,
        StTlow,
        StThigh,
        StFlush,
        StDone
    } state_e;

    localparam int unsigned TmsBit    = 1;
    localparam int unsigned TdiBit    = 0;
    localparam int unsigned CapAddrW  = 12;
    localparam logic        TmsRstVal = 1'b1;

endpackage

// File: rtl/jtag_tck_driver_if.sv
// Vector player handshake plus capture RAM write port, grouped for the driver.
interface jtag_tck_driver_if;
    import jtag_pkg::*;

    logic                get_next_data;
    logic                data_ready;
    logic [1:0]          vector_data;
    logic [CapAddrW-1:0] tdo_addr;
    logic [7:0]          tdo_wr_data;
    logic                tdo_we;

    modport master (
        output get_next_data,
        input  data_ready,
        input  vector_data,
        output tdo_addr,
        output tdo_wr_data,
        output tdo_we
    );

    modport slave (
        input  get_next_data,
        output data_ready,
        output vector_data,
        input  tdo_addr,
        input  tdo_wr_data,
        input  tdo_we
    );

endinterface

// File: rtl/tck_half_period_timer.sv
// Loadable down-counter timing one TCK half period; tc is high once the count
// has reached zero and stays there until the next load.
module tck_half_period_timer #(
    parameter int unsigned Width = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_value,
    output logic             tc
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/jtag_tck_driver.sv
// Pulls TMS/TDI steps from the vector player, drives TCK/TMS/TDI at CLK_DIV
// cycles per half period and packs sampled TDO bits into capture RAM bytes.
module jtag_tck_driver
    import jtag_pkg::*;
#(
    parameter int unsigned CLK_DIV = 30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [15:0]               num_steps,
    jtag_tck_driver_if.master         bus,
    output logic                      tck,
    output logic                      tms,
    output logic                      tdi,
    input  logic                      tdo,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned TimerW = $clog2(CLK_DIV + 1);
    localparam logic [TimerW-1:0] HalfLoad = TimerW'(CLK_DIV - 1);

    state_e              state_q;
    logic [15:0]         count_q;
    logic [15:0]         step_q;
    logic [15:0]         step_inc;
    logic [7:0]          bits_q;
    logic                tdo_meta_q;
    logic                tdo_sync_q;
    logic                gnd_q;
    logic                tck_q;
    logic                tms_q;
    logic                tdi_q;
    logic                we_q;
    logic [CapAddrW-1:0] addr_q;
    logic [7:0]          wdata_q;
    logic                busy_q;
    logic                done_q;
    logic                timer_load;
    logic                timer_tc;

    assign step_inc = step_q + 16'd1;

    // Each phase gets a fresh CLK_DIV count as it is entered.
    assign timer_load = ((state_q == StAck) && !bus.data_ready) ||
                        ((state_q == StTlow) && timer_tc);

    tck_half_period_timer #(
        .Width (TimerW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (HalfLoad),
        .tc         (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            step_q     <= '0;
            bits_q     <= '0;
            tdo_meta_q <= 1'b0;
            tdo_sync_q <= 1'b0;
            gnd_q      <= 1'b0;
            tck_q      <= 1'b0;
            tms_q      <= TmsRstVal;
            tdi_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tdo_meta_q <= tdo;
            tdo_sync_q <= tdo_meta_q;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (num_steps == 16'd0) begin
                            state_q <= StDone;
                        end else begin
                            count_q <= num_steps;
                            step_q  <= '0;
                            bits_q  <= '0;
                            gnd_q   <= 1'b1;
                            state_q <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (bus.data_ready) begin
                        tms_q   <= bus.vector_data[TmsBit];
                        tdi_q   <= bus.vector_data[TdiBit];
                        gnd_q   <= 1'b0;
                        state_q <= StAck;
                    end
                end
                StAck: begin
                    if (!bus.data_ready) begin
                        state_q <= StTlow;
                    end
                end
                StTlow: begin
                    if (timer_tc) begin
                        tck_q   <= 1'b1;
                        state_q <= StThigh;
                    end
                end
                StThigh: begin
                    if (timer_tc) begin
                        tck_q <= 1'b0;
                        if (step_q[2:0] == 3'd7) begin
                            we_q    <= 1'b1;
                            addr_q  <= step_q[CapAddrW+2:3];
                            wdata_q <= {tdo_sync_q, bits_q[6:0]};
                            bits_q  <= '0;
                        end else begin
                            bits_q[step_q[2:0]] <= tdo_sync_q;
                        end
                        step_q <= step_inc;
                        if (step_inc == count_q) begin
                            state_q <= StFlush;
                        end else begin
                            gnd_q   <= 1'b1;
                            state_q <= StReq;
                        end
                    end
                end
                StFlush: begin
                    // Bits above the last step are still zero from the clear.
                    if (step_q[2:0] != 3'd0) begin
                        we_q    <= 1'b1;
                        addr_q  <= step_q[CapAddrW+2:3];
                        wdata_q <= bits_q;
                    end
                    state_q <= StDone;
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.get_next_data = gnd_q;
    assign bus.tdo_addr      = addr_q;
    assign bus.tdo_wr_data   = wdata_q;
    assign bus.tdo_we        = we_q;
    assign tck               = tck_q;
    assign tms               = tms_q;
    assign tdi               = tdi_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_jtag_tck_driver.sv
// Directed bench for jtag_tck_driver: player and TDO target models, capture
// writes checked against a scoreboard of expected {addr, data} pairs.
module tb_jtag_tck_driver;

    localparam int unsigned CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_steps = '0;
    logic        tck, tms, tdi, busy, done;
    logic        tdo = 1'b0;

    jtag_tck_driver_if bus();

    jtag_tck_driver #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_steps (num_steps),
        .bus       (bus),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];
    logic [1:0]  vec_q[$];
    int          ply_delay = 0;
    int          tdo_mode = 0;
    int          tdo_base = 0;

    int          tck_rises = 0;
    int          tck_falls = 0;
    int          hi_len = 0;
    int          high_bad = 0;
    int          stall_bad = 0;
    int          since_chg = 0;
    int          gap_min = 1000;
    int          done_count = 0;
    int          gnd_rises = 0;
    logic        prev_tck = 1'b0;
    logic        prev_gnd = 1'b0;
    logic [1:0]  prev_pins = 2'b10;

    // Vector player: acknowledges each request after ply_delay cycles.
    initial begin
        bus.data_ready  = 1'b0;
        bus.vector_data = 2'b00;
        forever begin
            @(negedge clk);
            if (bus.get_next_data && !bus.data_ready) begin
                repeat (ply_delay) @(negedge clk);
                bus.vector_data = (vec_q.size() != 0) ? vec_q.pop_front() : 2'b11;
                bus.data_ready  = 1'b1;
            end else if (!bus.get_next_data && bus.data_ready) begin
                bus.data_ready = 1'b0;
            end
        end
    end

    // Pin monitor and TDO target: TDO updates after each TCK falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if ({tms, tdi} != prev_pins) since_chg = 0;
            else since_chg++;
            if (tck && !prev_tck) begin
                tck_rises++;
                if (since_chg < gap_min) gap_min = since_chg;
            end
            if (!tck && prev_tck) begin
                tck_falls++;
                if (!rst && hi_len != CLK_DIV) high_bad++;
            end
            hi_len = tck ? hi_len + 1 : 0;
            if (bus.get_next_data && !bus.data_ready && (tck || {tms, tdi} != prev_pins))
                stall_bad++;
            if (bus.get_next_data && !prev_gnd) gnd_rises++;
            if (bus.tdo_we) obs_q.push_back({bus.tdo_addr, bus.tdo_wr_data});
            if (done) done_count++;
            prev_tck  = tck;
            prev_gnd  = bus.get_next_data;
            prev_pins = {tms, tdi};
            case (tdo_mode)
                0:       tdo = 1'b0;
                1:       tdo = 1'b1;
                default: tdo = ((tck_falls - tdo_base) % 2) != 0;
            endcase
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " tck"}, 32'(tck), 32'd0);
        check({tag, " tms"}, 32'(tms), 32'd1);
        check({tag, " tdi"}, 32'(tdi), 32'd0);
        check({tag, " gnd"}, 32'(bus.get_next_data), 32'd0);
        check({tag, " we"}, 32'(bus.tdo_we), 32'd0);
        check({tag, " addr"}, 32'(bus.tdo_addr), 32'd0);
        check({tag, " wdata"}, 32'(bus.tdo_wr_data), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
    endtask

    task automatic drain(input string tag);
        logic [19:0] o;
        logic [19:0] e;
        while (obs_q.size() != 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                check({tag, " unexpected write"}, 32'(o), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check({tag, " write"}, 32'(o), 32'(e));
            end
        end
    endtask

    task automatic start_run(input logic [15:0] n);
        num_steps = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int max);
        logic seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            drain(tag);
            if (done) begin
                seen = 1'b1;
                check({tag, " busy at done"}, 32'(busy), 32'd0);
                break;
            end
        end
        check({tag, " done seen"}, 32'(seen), 32'd1);
        repeat (2) begin
            tick();
            drain(tag);
        end
        check({tag, " writes left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_rises(input string tag, input int target, input int max);
        logic hit = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (tck_rises >= target) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check({tag, " rise wait"}, 32'(hit), 32'd1);
    endtask

    initial begin
        int r0;
        int g0;
        int d0;

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset("reset");

        // Five steps, TDO high: one partial byte flushed as 0x1F.
        tdo_mode = 1;
        vec_q = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
        exp_q.push_back({12'd0, 8'h1F});
        r0 = tck_rises;
        start_run(16'd5);
        check("t1 gnd latency", 32'(bus.get_next_data), 32'd1);
        check("t1 busy rise", 32'(busy), 32'd1);
        run_until_done("t1", 2000);
        check("t1 pulses", 32'(tck_rises - r0), 32'd5);
        check("t1 tms", 32'(tms), 32'd1);
        check("t1 tdi", 32'(tdi), 32'd0);

        // Sixteen steps, alternating TDO: two full bytes, no flush write.
        tdo_mode = 2;
        tdo_base = tck_falls;
        for (int i = 0; i < 16; i++) vec_q.push_back(2'($urandom_range(0, 3)));
        exp_q.push_back({12'd0, 8'hAA});
        exp_q.push_back({12'd1, 8'hAA});
        r0 = tck_rises;
        start_run(16'd16);
        run_until_done("t2", 3000);
        check("t2 pulses", 32'(tck_rises - r0), 32'd16);

        // Zero steps: no request, no clock, done two cycles after start.
        r0 = tck_rises;
        g0 = gnd_rises;
        start_run(16'd0);
        check("t3 done early", 32'(done), 32'd0);
        tick();
        check("t3 done", 32'(done), 32'd1);
        tick();
        check("t3 pulses", 32'(tck_rises - r0), 32'd0);
        check("t3 requests", 32'(gnd_rises - g0), 32'd0);

        // Slow player: pins and TCK must hold through the 40-cycle stall.
        tdo_mode = 0;
        ply_delay = 40;
        vec_q = '{2'b01, 2'b10};
        exp_q.push_back({12'd0, 8'h00});
        start_run(16'd2);
        run_until_done("t4", 1000);
        ply_delay = 0;
        check("t4 stall", 32'(stall_bad), 32'd0);
        check("t4 setup gap", 32'(gap_min >= CLK_DIV), 32'd1);
        check("t4 tms", 32'(tms), 32'd1);
        check("t4 tdi", 32'(tdi), 32'd0);
        check("high width", 32'(high_bad), 32'd0);

        // Reset during the third of eight steps: no write, no done.
        tdo_mode = 1;
        for (int i = 0; i < 8; i++) vec_q.push_back(2'b00);
        r0 = tck_rises;
        start_run(16'd8);
        wait_rises("t5", r0 + 3, 500);
        rst = 1'b1;
        tick();
        check_reset("t5 rst");
        tick();
        rst = 1'b0;
        d0 = done_count;
        repeat (20) tick();
        check("t5 stray writes", 32'(obs_q.size()), 32'd0);
        check("t5 stray done", 32'(done_count - d0), 32'd0);
        obs_q.delete();
        vec_q.delete();
        exp_q.push_back({12'd0, 8'hFF});
        r0 = tck_rises;
        start_run(16'd8);
        run_until_done("t5 rerun", 2000);
        check("t5 pulses", 32'(tck_rises - r0), 32'd8);

        // Start pulsed mid-run is ignored; ten steps still run to completion.
        tdo_mode = 2;
        tdo_base = tck_falls;
        for (int i = 0; i < 10; i++) vec_q.push_back(2'b01);
        exp_q.push_back({12'd0, 8'hAA});
        exp_q.push_back({12'd1, 8'h02});
        r0 = tck_rises;
        start_run(16'd10);
        wait_rises("t6", r0 + 2, 500);
        start_run(16'd3);
        run_until_done("t6", 2000);
        check("t6 pulses", 32'(tck_rises - r0), 32'd10);
        check("t6 high width", 32'(high_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
